// File: rtl/vram_arb_pkg.sv
// Shared widths and per-stage access state for the VRAM slot arbiter.
package vram_arb_pkg;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int HW = 9;

  typedef enum logic [1:0] {IDLE = 2'd0, VID_RD = 2'd1, CPU_RD = 2'd2, CPU_WR = 2'd3} stage_t;

  function automatic logic is_cpu(stage_t s);
    return (s == CPU_RD) || (s == CPU_WR);
  endfunction
endpackage

// File: rtl/vram_slot_arbiter_arb_rr2.sv
// Two-way round-robin for blanking contention (bit 0 = video, bit 1 = CPU).
// Only built when VRAM_ARB_FAIR_EN is defined.
`ifdef VRAM_ARB_FAIR_EN
module arb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // last winner: 0 = video, 1 = CPU; resets to video so CPU wins first contention
  logic last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)     last <= 1'b0;
    else if (|gnt) last <= gnt[1];
endmodule
`endif

// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: video/CPU share a sync RAM; arbitrate, drive RAM, ack.
// VRAM_ARB_FAIR_EN selects round-robin (vs video priority) during blanking.
module vram_slot_arbiter
  import vram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [HW-1:0] hc,
  input  logic [HW-1:0] vc,
  input  logic          hbl,
  input  logic          vbl,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  stage_t        st_mem, st_ack, st_nxt;
  logic          active, vid_busy, cpu_busy, vid_elig, cpu_elig;
  logic          gnt_vid, gnt_cpu;
  logic [1:0]    bl_gnt;
  logic [DW-1:0] vid_q, cpu_q;
  logic          unused_in;

  // Slot parity only matters through hc[0]; vertical position is not used.
  assign unused_in = ^{vc, hc[HW-1:1]};

  assign active   = !hbl && !vbl;
  // A requester stays busy from grant until its ack cycle has passed.
  assign vid_busy = (st_mem == VID_RD) || (st_ack == VID_RD);
  assign cpu_busy = is_cpu(st_mem) || is_cpu(st_ack);
  assign vid_elig = vid_req && !vid_busy;
  assign cpu_elig = cpu_req && !cpu_busy;

`ifdef VRAM_ARB_FAIR_EN
  logic [1:0] bl_req;
  assign bl_req = active ? 2'b00 : {cpu_elig, vid_elig};
  arb_rr2 u_rr (.clk(clk), .reset(reset), .req(bl_req), .gnt(bl_gnt));
`else
  assign bl_gnt = active   ? 2'b00 :
                  vid_elig ? 2'b01 : {cpu_elig, 1'b0};
`endif

  assign gnt_vid = active ? (vid_elig && !hc[0]) : bl_gnt[0];
  assign gnt_cpu = active ? (cpu_elig &&  hc[0]) : bl_gnt[1];

  always_comb begin
    st_nxt = IDLE;
    if (gnt_vid)      st_nxt = VID_RD;
    else if (gnt_cpu) st_nxt = cpu_we ? CPU_WR : CPU_RD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mem   <= IDLE;
      st_ack   <= IDLE;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
      vid_q    <= '0;
      cpu_q    <= '0;
    end else begin
      st_mem <= st_nxt;
      st_ack <= st_mem;
      mem_we <= 1'b0;
      if (gnt_vid) begin
        mem_addr <= vid_addr;
      end else if (gnt_cpu) begin
        mem_addr <= cpu_addr;
        mem_we   <= cpu_we;
        mem_din  <= cpu_din;
      end
      if (st_ack == VID_RD) vid_q <= mem_dout;
      if (st_ack == CPU_RD) cpu_q <= mem_dout;
    end
  end

  // RAM data arrives in the ack cycle; pass it through, then hold it.
  assign vid_ack  = (st_ack == VID_RD);
  assign cpu_ack  = is_cpu(st_ack);
  assign vid_dout = (st_ack == VID_RD) ? mem_dout : vid_q;
  assign cpu_dout = (st_ack == CPU_RD) ? mem_dout : cpu_q;
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: directed slot scenarios plus random traffic
// checked against a grant-log reference model.
module tb_vram_slot_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic [8:0]  hc = '0, vc = '0;
  logic        hbl = 1'b0, vbl = 1'b0;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [14:0] vid_addr = '0, cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic        vid_ack, cpu_ack, mem_we;
  logic [15:0] vid_dout, cpu_dout, mem_din;
  logic [14:0] mem_addr;
  logic [15:0] mem_dout = '0;

  vram_slot_arbiter dut (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .hbl(hbl), .vbl(vbl),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // synchronous RAM environment
  logic [15:0] ram [0:32767];
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_din;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: log of grants per cycle (0 none, 1 video, 2 CPU)
  logic [15:0] ref_mem [0:32767];
  int          cyc;
  int          rec_who [4];
  logic [14:0] rec_addr [4];
  logic        rec_we [4];
  logic [15:0] rec_din [4], rec_data [4];
  logic [14:0] last_addr;
  logic [15:0] exp_vd, exp_cd;
  int          last_win;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rec_who[i] = 0;
    last_addr = '0; exp_vd = '0; exp_cd = '0; last_win = 1;
  endtask

  task automatic check_outputs();
    int p1 = (cyc - 1) & 3;
    int p2 = (cyc - 2) & 3;
    if (rec_who[p1] != 0) begin
      chk("mem_addr", mem_addr, rec_addr[p1]);
      chk("mem_we", mem_we, rec_we[p1]);
      if (rec_we[p1]) chk("mem_din", mem_din, rec_din[p1]);
      last_addr = rec_addr[p1];
    end else begin
      chk("idle_we", mem_we, 0);
      chk("idle_addr", mem_addr, last_addr);
    end
    chk("vid_ack", vid_ack, rec_who[p2] == 1);
    chk("cpu_ack", cpu_ack, rec_who[p2] == 2);
    if (rec_who[p2] == 1) exp_vd = rec_data[p2];
    if (rec_who[p2] == 2 && !rec_we[p2]) exp_cd = rec_data[p2];
    chk("vid_dout", vid_dout, exp_vd);
    chk("cpu_dout", cpu_dout, exp_cd);
  endtask

  task automatic model_grant();
    int  c0 = cyc & 3, p1 = (cyc - 1) & 3, p2 = (cyc - 2) & 3;
    int  who = 0;
    bit  act = !hbl && !vbl;
    bit  ve = vid_req && !(rec_who[p1] == 1 || rec_who[p2] == 1);
    bit  ce = cpu_req && !(rec_who[p1] == 2 || rec_who[p2] == 2);
    if (act) begin
      if (!hc[0] && ve) who = 1;
      else if (hc[0] && ce) who = 2;
    end else if (ve && ce) begin
`ifdef VRAM_ARB_FAIR_EN
      who = (last_win == 2) ? 1 : 2;
`else
      who = 1;
`endif
    end else if (ve) who = 1;
    else if (ce) who = 2;
    if (!act && who != 0) last_win = who;
    rec_who[c0] = who;
    if (who == 1) begin
      rec_addr[c0] = vid_addr; rec_we[c0] = 1'b0; rec_data[c0] = ref_mem[vid_addr];
    end else if (who == 2) begin
      rec_addr[c0] = cpu_addr; rec_we[c0] = cpu_we; rec_din[c0] = cpu_din;
      if (cpu_we) ref_mem[cpu_addr] = cpu_din;
      else rec_data[c0] = ref_mem[cpu_addr];
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    model_grant();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic set_timing(input int h, input int v);
    hc = 9'(h); vc = 9'(v);
    hbl = (h >= 40); vbl = (v >= 6);
  endtask

  int nv, nc;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i]     = 16'(i * 40503) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
    end
    #2 reset = 1'b1;
    #2;
    chk("rst_vid_ack", vid_ack, 0);  chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mem_we", mem_we, 0);    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);  chk("rst_vid_dout", vid_dout, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    cyc = 8; model_reset();

    // Reset during the memory stage of a CPU read drops the access.
    set_timing(40, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0055;
    run_cycle();
    cpu_req = 0;
    #2 reset = 1'b1;
    #1;
    chk("r30_mem_addr", mem_addr, 0); chk("r30_mem_we", mem_we, 0);
    chk("r30_cpu_ack", cpu_ack, 0);   chk("r30_cpu_dout", cpu_dout, 0);
    @(posedge clk); #1;
    chk("r30_no_ack", cpu_ack, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Blanking contention right after reset; first winner depends on mode.
    vid_req = 1; cpu_req = 1; cpu_we = 0;
    nv = 0; nc = 0;
    for (int i = 0; i < 9; i++) begin
      set_timing(40 + i, 0);
      vid_addr = 15'($urandom_range(0, 63)); cpu_addr = 15'($urandom_range(0, 63));
      run_cycle();
      if (i == 1) begin
`ifdef VRAM_ARB_FAIR_EN
        chk("r28_first", {vid_ack, cpu_ack}, 2'b01);
`else
        chk("r28_first", {vid_ack, cpu_ack}, 2'b10);
`endif
      end
      nv += int'(vid_ack); nc += int'(cpu_ack);
    end
    chk("r28_vid_cnt", nv, 3);
    chk("r28_cpu_cnt", nc, 3);
    vid_req = 0; cpu_req = 0;
    repeat (3) run_cycle();

    // Preload 0xBEEF at 0x0100 through a blanking CPU write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0100; cpu_din = 16'hBEEF;
    run_cycle();
    cpu_req = 0;
    repeat (3) run_cycle();

    // Active video read on an even slot.
    set_timing(10, 0); vid_req = 1; vid_addr = 15'h0100;
    run_cycle();
    set_timing(11, 0); vid_req = 0;
    chk("r26_mem_addr", mem_addr, 15'h0100);
    run_cycle();
    set_timing(12, 0);
    chk("r26_vid_ack", vid_ack, 1);
    chk("r26_vid_dout", vid_dout, 16'hBEEF);
    run_cycle();
    set_timing(13, 0); run_cycle();

    // Active CPU write requested on an even slot waits for the odd one.
    set_timing(14, 0); cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0200; cpu_din = 16'h1234;
    run_cycle();
    set_timing(15, 0); run_cycle();
    set_timing(16, 0); cpu_req = 0; cpu_addr = 15'h7FFF; cpu_din = 16'h0000;
    chk("r27_mem_we", mem_we, 1);
    chk("r27_mem_addr", mem_addr, 15'h0200);
    chk("r27_mem_din", mem_din, 16'h1234);
    run_cycle();
    set_timing(17, 0);
    chk("r27_cpu_ack", cpu_ack, 1);
    run_cycle();
    set_timing(18, 0);
    chk("r27_ram", ram[15'h0200], 16'h1234);
    run_cycle();

    // Active, CPU only, held for 8 cycles.
    cpu_req = 1; cpu_we = 0; nc = 0;
    for (int h = 20; h < 28; h++) begin
      set_timing(h, 0); cpu_addr = 15'($urandom_range(0, 63));
      run_cycle();
      nc += int'(cpu_ack);
    end
    chk("r29_acks", nc, 2);
    cpu_req = 0;
    repeat (3) run_cycle();

    // Random traffic across active and blanking, including hc wrap.
    for (int i = 0; i < 1500; i++) begin
      set_timing(i % 48, (i / 48) % 8);
      vid_req  = ($urandom % 4) != 0;
      vid_addr = 15'($urandom_range(0, 63));
      cpu_req  = 1'($urandom);
      cpu_we   = 1'($urandom);
      cpu_addr = 15'($urandom_range(0, 63));
      cpu_din  = 16'($urandom);
      run_cycle();
    end
    vid_req = 0; cpu_req = 0;
    repeat (4) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_slot_arbiter.md
VRAM_SLOT_ARBITER -- requirements
Module: vram_slot_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system pixel clock (sole clock).
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports: hc  in  9  horizontal counter from timing generator; vc  in  9  vertical counter.
REQ-004 SHALL have ports: hbl  in  1  horizontal blank; vbl  in  1  vertical blank.
REQ-005 SHALL have ports: vid_req  in  1  video fetch request (level); vid_addr  in  15  video word address; vid_ack  out  1  one-cycle read-done pulse; vid_dout  out  16  read data.
REQ-006 SHALL have ports: cpu_req  in  1  CPU request (level); cpu_we  in  1  write enable; cpu_addr  in  15; cpu_din  in  16; cpu_ack  out  1  one-cycle done pulse; cpu_dout  out  16.
REQ-007 SHALL have ports: mem_addr  out  15; mem_we  out  1; mem_din  out  16; mem_dout  in  16  synchronous RAM data, valid one cycle after address.

Function
REQ-008 SHALL define active = !hbl && !vbl, sampled in the arbitration cycle.
REQ-009 SHALL, during active, offer even-hc slots only to video and odd-hc slots only to CPU; an unused slot stays idle.
REQ-010 SHALL, during blanking, offer every slot to either requester per REQ-020.
REQ-011 SHALL run a 3-stage pipeline: cycle N arbitrate; N+1 registered mem_addr/mem_we/mem_din driven; N+2 ack pulse with data captured from mem_dout.
REQ-012 SHALL allow one grant per cycle, back-to-back grants to different requesters.
REQ-013 SHALL hold at most one outstanding access per requester; a requester is ineligible from grant until the cycle after its ack.
REQ-014 SHALL latch address/we/din at grant; requester changes after grant do not affect the access.
REQ-015 SHALL drive mem_we=1 only in stage 2 of a CPU write; video accesses are always reads.
REQ-016 SHALL, on CPU write, pulse cpu_ack at N+2; cpu_dout retains its previous value.
REQ-017 SHALL, when idle, drive mem_we=0 and hold mem_addr at last value.
REQ-018 SHALL treat hc wrap (HTOTAL to 0) and blank edges purely by sampled hc[0]/active; no slot state carries across lines.
REQ-019 SHALL track pipeline with state per stage: IDLE, VID_RD, CPU_RD, CPU_WR.

Reset
REQ-020 (see Configuration) fixed here as reset-affecting: round-robin pointer resets to "video last", giving CPU first blanking win.
REQ-021 SHALL, on reset, force all outputs to 0, all stages to IDLE, outstanding flags cleared.
REQ-022 SHALL drop any in-flight access on reset mid-operation; no ack is issued for it.

Configuration
REQ-023 SHALL use macro VRAM_ARB_FAIR_EN: defined -> blanking contention resolved by 2-way round-robin (winner alternates); undefined -> video has fixed priority in blanking, REQ-020 pointer absent.

Structure
REQ-024 SHALL place address/data width localparams and the stage-state enum in package vram_arb_pkg.
REQ-025 SHALL implement blanking arbitration in sub-module arb_rr2 (2 requests, grant one-hot, pointer update on grant), instantiated only under VRAM_ARB_FAIR_EN.

Verification
REQ-026 Active, hc=10, vid_req=1 addr 0x0100, RAM[0x0100]=0xBEEF -> mem_addr=0x0100 at hc=11, vid_ack=1 vid_dout=0xBEEF at hc=12.
REQ-027 Active, cpu_req=1 at hc=10 (even), we=1 addr 0x0200 din 0x1234 -> grant at hc=11, mem_we=1 at hc=12, cpu_ack at hc=13, RAM[0x0200]=0x1234.
REQ-028 Blanking, both req held, FAIR_EN -> grants alternate CPU,VID,CPU... respecting REQ-013; without macro -> video granted every eligible slot.
REQ-029 Active, only cpu_req held 8 cycles -> no grant on even hc; acks spaced per REQ-013.
REQ-030 Assert reset in stage 2 of CPU read -> no cpu_ack, all outputs 0 next edge; after release a new request completes in 3 cycles.
